pwm_multi: RTL and testbench

Multi-channel PWM generator: N outputs share one prescaler and one duty counter, each with its own duty value. Duty updates are double-buffered and take effect only at a period boundary, so a channel never emits a glitched or truncated pulse. A period-boundary strobe lets software or a sequencer, such as the rainbow colour stepper, update duties synchronously. An optional center-aligned (up/down) counting mode is available.

---
 rtl/pwm_multi.sv | 112 +++++++++++
 tb/tb_pwm_multi.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// N-channel PWM sharing one prescaler and one duty counter; duties are double-buffered
// and swap in at the period boundary. Define PWM_MULTI_CENTER_EN to build center-aligned mode.
module pwm_multi #(
  parameter int R = 8,
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        dvsr,
  input  logic [N*(R+1)-1:0] duty,
  input  logic               duty_wr,
  input  logic               mode,
  output logic [N-1:0]       pwm_out,
  output logic               period_tick
);

  localparam logic [R-1:0] D_MAX = '1;
  localparam logic [R-1:0] D_ONE = {{(R-1){1'b0}}, 1'b1};

  logic [31:0]  q;
  logic         tick;
  logic [R-1:0] d;
  logic         boundary;
  logic [R:0]   shadow [N];
  logic [R:0]   active [N];
  logic [N-1:0] pwm_p0;

  assign tick = (q == 32'd0);

  // >= rather than == so a lowered dvsr recovers in one cycle instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= (q >= dvsr) ? 32'd0 : q + 32'd1;
  end

`ifdef PWM_MULTI_CENTER_EN
  logic dir_dn;
  logic mode_r;

  assign boundary = tick && (mode_r ? (dir_dn && (d == D_ONE)) : (d == D_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d      <= '0;
      dir_dn <= 1'b0;
      mode_r <= 1'b0;
    end else if (boundary) begin
      d      <= '0;
      dir_dn <= 1'b0;
      mode_r <= mode;
    end else if (tick) begin
      if (!mode_r) begin
        d <= d + D_ONE;
      end else if (!dir_dn) begin
        if (d == D_MAX) begin
          dir_dn <= 1'b1;
          d      <= d - D_ONE;
        end else begin
          d <= d + D_ONE;
        end
      end else begin
        d <= d - D_ONE;
      end
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  assign boundary = tick && (d == D_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n)        d <= '0;
    else if (boundary) d <= '0;
    else if (tick)     d <= d + D_ONE;
  end
`endif

  // Active takes the pre-write shadow when a write lands on the boundary cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (duty_wr) begin
        for (int i = 0; i < N; i++) shadow[i] <= duty[i*(R+1) +: (R+1)];
      end
      if (boundary) begin
        for (int i = 0; i < N; i++) active[i] <= shadow[i];
      end
    end
  end

  always_comb begin
    pwm_p0 = '0;
    for (int i = 0; i < N; i++) pwm_p0[i] = ({1'b0, d} < active[i]);
  end

  // output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_out     <= '0;
      period_tick <= 1'b0;
    end else begin
      pwm_out     <= pwm_p0;
      period_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: per-cycle comparison against a tick/position reference model,
// plus directed duty-count and period-spacing checks.
module tb_pwm_multi;
  localparam int R = 8;
  localparam int N = 3;
  localparam int W = R + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [31:0]    dvsr = '0;
  logic [N*W-1:0] duty = '0;
  logic           duty_wr = 1'b0;
  logic           mode = 1'b0;
  logic [N-1:0]   pwm_out;
  logic           period_tick;

  int n_assert = 0;
  int n_fail = 0;

  pwm_multi #(.R(R), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .dvsr(dvsr), .duty(duty), .duty_wr(duty_wr),
    .mode(mode), .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  // Reference model: clocks since last tick, ticks since last boundary, duty buffers
  int unsigned mq;
  int          pos;
  int          shad [N];
  int          act [N];
  bit          mmode;
  int          hi [N];
  int          nticks;

  function automatic int plen();
    return mmode ? (2 * (1 << R) - 2) : (1 << R);
  endfunction

  function automatic int dval();
    if (mmode && pos >= (1 << R)) return 2 * (1 << R) - 2 - pos;
    return pos;
  endfunction

  function automatic bit bnd_next();
    return rst_n && (mq == 0) && (pos == plen() - 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] ep;
    logic         ept;
    bit           tk, b;
    ep  = '0;
    ept = 1'b0;
    if (!rst_n) begin
      mq = 0; pos = 0; mmode = 1'b0;
      for (int i = 0; i < N; i++) begin shad[i] = 0; act[i] = 0; end
    end else begin
      tk = (mq == 0);
      b  = tk && (pos == plen() - 1);
      for (int i = 0; i < N; i++) ep[i] = (dval() < act[i]);
      ept = b;
      if (b) for (int i = 0; i < N; i++) act[i] = shad[i];
      if (duty_wr) for (int i = 0; i < N; i++) shad[i] = int'(duty[i*W +: W]);
      if (b) begin
        pos = 0;
`ifdef PWM_MULTI_CENTER_EN
        mmode = mode;
`endif
      end else if (tk) begin
        pos++;
      end
      mq = (mq >= dvsr) ? 0 : mq + 1;
    end
    @(posedge clk);
    #1;
    check("pwm_out", {29'd0, pwm_out}, {29'd0, ep});
    check("period_tick", {31'd0, period_tick}, {31'd0, ept});
  endtask

  task automatic set_duty(input int a, input int b, input int c);
    duty    = {W'(c), W'(b), W'(a)};
    duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
  endtask

  task automatic measure(input int clocks);
    for (int i = 0; i < N; i++) hi[i] = 0;
    nticks = 0;
    repeat (clocks) begin
      step();
      for (int i = 0; i < N; i++) hi[i] += int'(pwm_out[i]);
      nticks += int'(period_tick);
    end
  endtask

  task automatic wait_ptick(input int limit, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (period_tick !== 1'b1 && cnt < limit);
    check("ptick_seen", {31'd0, period_tick}, 32'd1);
  endtask

  initial begin
    int cnt;
    int g;

    // reset state
    step();
    step();
    check("reset_pwm", {29'd0, pwm_out}, 32'd0);
    check("reset_ptick", {31'd0, period_tick}, 32'd0);
    rst_n = 1'b1;

    // basic duties, dvsr=0
    dvsr = 0;
    set_duty(64, 128, 256);
    wait_ptick(2000, cnt);
    wait_ptick(2000, cnt);
    check("edge_spacing", cnt, 256);
    measure(256);
    check("ch0_hi64", hi[0], 64);
    check("ch1_hi128", hi[1], 128);
    check("ch2_full", hi[2], 256);
    check("ticks_per_period", nticks, 1);

    // duty 0 with continuous writes
    duty    = '0;
    duty_wr = 1'b1;
    wait_ptick(2000, cnt);
    wait_ptick(2000, cnt);
    measure(512);
    duty_wr = 1'b0;
    check("zero_ch0", hi[0], 0);
    check("zero_ch1", hi[1], 0);
    check("zero_ch2", hi[2], 0);
    check("zero_ticks", nticks, 2);

    // mid-period update and boundary-coincident write, dvsr=3
    dvsr = 3;
    set_duty(200, 0, 0);
    wait_ptick(5000, cnt);
    wait_ptick(5000, cnt);
    measure(1024);
    check("ch0_200x4", hi[0], 800);
    repeat (100) step();
    set_duty(10, 0, 0);
    wait_ptick(5000, cnt);
    measure(1024);
    check("ch0_10x4", hi[0], 40);
    check("ticks_dvsr3", nticks, 1);
    g = 0;
    while (!bnd_next() && g < 2000) begin step(); g++; end
    set_duty(77, 0, 0);
    check("write_on_boundary", {31'd0, period_tick}, 32'd1);
    measure(1024);
    check("deferred_old", hi[0], 40);
    measure(1024);
    check("deferred_new", hi[0], 308);

    // dvsr lowered below q
    dvsr = 100;
    g = 0;
    while (mq != 50 && g < 500) begin step(); g++; end
    dvsr = 5;
    wait_ptick(5000, cnt);
    wait_ptick(5000, cnt);
    check("dvsr5_spacing", cnt, 6 * 256);

    // randomized duties and writes
    dvsr = $urandom_range(0, 2);
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) begin
        duty = {W'($urandom_range(0, 300)), W'($urandom_range(0, 300)), W'($urandom_range(0, 300))};
        duty_wr = 1'b1;
      end else begin
        duty_wr = 1'b0;
      end
      if ($urandom_range(0, 499) == 0) dvsr = $urandom_range(0, 2);
      step();
    end
    duty_wr = 1'b0;

    // reset mid-period clears active duty
    dvsr = 0;
    set_duty(200, 0, 0);
    wait_ptick(5000, cnt);
    wait_ptick(5000, cnt);
    repeat (100) step();
    rst_n = 1'b0;
    step();
    check("midrst_pwm", {29'd0, pwm_out}, 32'd0);
    check("midrst_ptick", {31'd0, period_tick}, 32'd0);
    rst_n = 1'b1;
    measure(600);
    check("post_rst_low", hi[0], 0);
    set_duty(200, 0, 0);
    wait_ptick(2000, cnt);
    measure(256);
    check("post_rst_200", hi[0], 200);

`ifdef PWM_MULTI_CENTER_EN
    // center-aligned mode
    mode = 1'b1;
    set_duty(128, 0, 300);
    wait_ptick(2000, cnt);
    wait_ptick(2000, cnt);
    check("center_spacing", cnt, 510);
    measure(510);
    check("center_ch0", hi[0], 255);
    check("center_ch2", hi[2], 510);
    check("center_ticks", nticks, 1);
    mode = 1'b0;
    repeat (10) step();
    wait_ptick(2000, cnt);
    check("mode_deferred", cnt, 500);
    wait_ptick(2000, cnt);
    check("back_to_edge", cnt, 256);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
